// File: rtl/serial_mul_pkg.sv
// Shared widths, step count, FSM state type and a helper for serial_top_multiplier.
// The optional serial shift-out stage is selected by the SERIAL_MUL_SOUT_EN macro.
package serial_mul_pkg;

    localparam int XW        = 11;
    localparam int YW        = 12;
    localparam int ZW        = 23;
    localparam int MUL_STEPS = 23;
    localparam int CW        = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV,
        ST_MULT,
        ST_FIX,
        ST_SOUT,
        ST_DONE
    } state_t;

    // Two's-complement negate when neg is set; result wraps modulo 2^ZW.
    function automatic logic [ZW-1:0] cond_neg(input logic [ZW-1:0] v, input logic neg);
        return neg ? (~v + ZW'(1)) : v;
    endfunction

endpackage

// File: rtl/unsigned_shift_add_mult.sv
// Unsigned 23x23 shift-add multiplier core; one iteration per clock, product kept modulo 2^23.
module unsigned_shift_add_mult
    import serial_mul_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [ZW-1:0] a,
    input  logic [ZW-1:0] b,
    output logic [ZW-1:0] p,
    output logic          done
);

    logic [ZW-1:0] mcand_reg;
    logic [ZW-1:0] mplier_reg;
    logic [ZW-1:0] acc_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;

    assign p = acc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand_reg  <= a;
                mplier_reg <= b;
                acc_reg    <= '0;
                cnt_reg    <= CW'(MUL_STEPS);
                busy_reg   <= 1'b1;
            end else if (busy_reg) begin
                if (mplier_reg[0])
                    acc_reg <= acc_reg + mcand_reg;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg - CW'(1);
                // Done is registered on the last iteration, so it is seen the cycle after.
                if (cnt_reg == CW'(1)) begin
                    busy_reg <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/serial_top_multiplier.sv
// Bit-serial signed/unsigned 11x12 multiplier with serial load and optional serial unload.
// Define SERIAL_MUL_SOUT_EN to include the 23-cycle serial shift-out stage.
module serial_top_multiplier
    import serial_mul_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          y,
    input  logic          x,
    input  logic          mul,
    input  logic          sx,
    input  logic          sy,
    output logic          fx,
    output logic          fy,
    output logic          unsigned_done,
    output logic [ZW-1:0] z,
    output logic          z_serial,
    output logic          z_done,
    output logic [YW-1:0] y_shift,
    output logic [XW-1:0] x_shift
);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [XW-1:0] x_neg;
    logic [YW-1:0] y_neg;
    logic [ZW-1:0] a_mag;
    logic [ZW-1:0] b_mag;
    logic [ZW-1:0] p_mag;
    logic [ZW-1:0] z_fixed;
    logic          start;

    assign fx    = sx & x_shift[XW-1];
    assign fy    = sy & y_shift[YW-1];
    // Negating the most negative value yields itself, which read unsigned is the right magnitude.
    assign x_neg = ~x_shift + XW'(1);
    assign y_neg = ~y_shift + YW'(1);
    assign a_mag = ZW'(fx ? x_neg : x_shift);
    assign b_mag = ZW'(fy ? y_neg : y_shift);
    assign start = (state_reg == ST_CONV);
    assign z_fixed = cond_neg(p_mag, fx ^ fy);

    unsigned_shift_add_mult u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_mag),
        .b     (b_mag),
        .p     (p_mag),
        .done  (unsigned_done)
    );

`ifdef SERIAL_MUL_SOUT_EN
    logic [ZW-1:0] sreg_reg;
    assign z_serial = sreg_reg[0];
`else
    assign z_serial = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            x_shift   <= '0;
            y_shift   <= '0;
            z         <= '0;
            z_done    <= 1'b0;
`ifdef SERIAL_MUL_SOUT_EN
            sreg_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (mul) begin
                        x_shift   <= {x, x_shift[XW-1:1]};
                        y_shift   <= {y, y_shift[YW-1:1]};
                        cnt_reg   <= CW'(1);
                        z_done    <= 1'b0;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // cnt_reg holds the number of bits already captured.
                    y_shift <= {y, y_shift[YW-1:1]};
                    if (cnt_reg < CW'(XW))
                        x_shift <= {x, x_shift[XW-1:1]};
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(YW-1))
                        state_reg <= ST_CONV;
                end
                ST_CONV: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_MULT;
                end
                ST_MULT: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(MUL_STEPS-1))
                        state_reg <= ST_FIX;
                end
                ST_FIX: begin
                    z       <= z_fixed;
                    cnt_reg <= '0;
`ifdef SERIAL_MUL_SOUT_EN
                    sreg_reg  <= z_fixed;
                    state_reg <= ST_SOUT;
`else
                    z_done    <= 1'b1;
                    state_reg <= ST_DONE;
`endif
                end
                ST_SOUT: begin
`ifdef SERIAL_MUL_SOUT_EN
                    sreg_reg <= sreg_reg >> 1;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(ZW-1)) begin
                        z_done    <= 1'b1;
                        state_reg <= ST_DONE;
                    end
`else
                    state_reg <= ST_IDLE;
`endif
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_top_multiplier.sv
// Randomized and directed bench for serial_top_multiplier against an arithmetic reference model.
module tb_serial_top_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        y, x, mul, sx, sy;
    logic        fx, fy, unsigned_done, z_serial, z_done;
    logic [22:0] z;
    logic [11:0] y_shift;
    logic [10:0] x_shift;

    int compared = 0;
    int mismatched = 0;

`ifdef SERIAL_MUL_SOUT_EN
    localparam int ZDONE_EDGE = 60;
    localparam bit SOUT_ON    = 1'b1;
`else
    localparam int ZDONE_EDGE = 37;
    localparam bit SOUT_ON    = 1'b0;
`endif

    serial_top_multiplier dut (
        .clk           (clk),
        .rst           (rst),
        .y             (y),
        .x             (x),
        .mul           (mul),
        .sx            (sx),
        .sy            (sy),
        .fx            (fx),
        .fy            (fy),
        .unsigned_done (unsigned_done),
        .z             (z),
        .z_serial      (z_serial),
        .z_done        (z_done),
        .y_shift       (y_shift),
        .x_shift       (x_shift)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] ref_product(input logic [10:0] xv, input logic [11:0] yv,
                                                input bit sxv, input bit syv);
        int xs;
        int ys;
        int prod;
        xs = int'(xv);
        ys = int'(yv);
        if (sxv && xv[10]) xs = xs - 2048;
        if (syv && yv[11]) ys = ys - 4096;
        prod = xs * ys;
        return 23'(prod);
    endfunction

    // One full transaction starting from IDLE or DONE; edge 1 is the first capture edge.
    task automatic run_op(input logic [10:0] xv, input logic [11:0] yv, input bit sxv, input bit syv);
        logic [22:0] zexp;
        logic [22:0] ser;
        int          ud_cnt;
        int          ud_edge;
        int          zd_edge;
        zexp    = ref_product(xv, yv, sxv, syv);
        ser     = '0;
        ud_cnt  = 0;
        ud_edge = 0;
        zd_edge = 0;
        sx = sxv;
        sy = syv;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mul = (i == 0);
            x   = (i < 11) ? xv[i] : 1'($urandom_range(1));
            y   = yv[i];
            @(posedge clk);
            #1;
            if (i == 0) chk("z_done_clear", 64'(z_done), 64'(0));
        end
        chk("x_shift", 64'(x_shift), 64'(xv));
        chk("y_shift", 64'(y_shift), 64'(yv));
        chk("flags", 64'({fx, fy}), 64'({sxv & xv[10], syv & yv[11]}));
        for (int n = 13; n <= 62; n++) begin
            @(negedge clk);
            mul = 1'b0;
            x   = 1'($urandom_range(1));
            y   = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            if (unsigned_done) begin
                ud_cnt++;
                if (ud_edge == 0) ud_edge = n;
            end
            if (z_done && zd_edge == 0) zd_edge = n;
            if (n >= 37 && n <= 59) ser[n-37] = z_serial;
            if (n == 37) chk("z", 64'(z), 64'(zexp));
        end
        chk("ud_edge", 64'(ud_edge), 64'(36));
        chk("ud_count", 64'(ud_cnt), 64'(1));
        chk("zd_edge", 64'(zd_edge), 64'(ZDONE_EDGE));
        chk("z_hold", 64'(z), 64'(zexp));
        chk("z_serial", 64'(ser), SOUT_ON ? 64'(zexp) : 64'(0));
        $display("op x=%03h y=%03h sx=%0d sy=%0d -> z=%06h expected %06h", xv, yv, sxv, syv, z, zexp);
    endtask

    initial begin
        rst = 1'b1;
        mul = 1'b0;
        x = 1'b0; y = 1'b0; sx = 1'b0; sy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 64'({fx, fy, unsigned_done, z, z_serial, z_done, y_shift, x_shift}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op(11'h7FF, 12'h800, 1'b1, 1'b1);
        run_op(11'h7FF, 12'h800, 1'b0, 1'b0);
        run_op(11'h7FD, 12'h005, 1'b1, 1'b0);
        run_op(11'h000, 12'($urandom), 1'b1, 1'b1);

        // Abort mid-multiply with an asynchronous reset, then recover.
        sx = 1'b0;
        sy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mul = (i == 0);
            x   = 1'($urandom_range(1));
            y   = 1'($urandom_range(1));
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_outs", 64'({fx, fy, unsigned_done, z, z_serial, z_done, y_shift, x_shift}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        mul = 1'b0;
        $display("abort reset applied during MULT");
        run_op(11'd5, 12'd7, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++)
            run_op(11'($urandom), 12'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_top_multiplier.md
# serial_top_multiplier

Bit-serial signed/unsigned multiplier. It shifts in an 11-bit operand X and a 12-bit operand Y one bit per clock, optionally treats each as two's complement, and multiplies the magnitudes with a 23-step shift-add core. It then sign-corrects the 23-bit product Z and shifts Z back out serially. It sits between serial links and a parallel datapath; the loaded operands and the parallel product are also exposed.

## Interface
- Parameters: none (widths fixed: X 11, Y 12, Z 23).
- One clock; reset is asynchronous and active-high. Clock port `clk`, reset port `rst`.
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- y  in  1  serial Y data, LSB first
- x  in  1  serial X data, LSB first
- mul  in  1  start; sampled in IDLE
- sx  in  1  1 = X is two's complement
- sy  in  1  1 = Y is two's complement
- fx  out  1  X negative flag: sx & x_shift[10]
- fy  out  1  Y negative flag: sy & y_shift[11]
- unsigned_done  out  1  one-cycle pulse: magnitude product complete
- z  out  23  signed (or unsigned) product, valid from unsigned_done+1
- z_serial  out  1  serial product, LSB first
- z_done  out  1  level; serial shift-out finished
- y_shift  out  12  Y shift register
- x_shift  out  11  X shift register

## Operation
- States: IDLE, LOAD, CONV, MULT, FIX, SOUT, DONE.
- IDLE, mul=1: the same edge captures bit 0 of both operands and moves to LOAD.
  - Shift-in is right shift with the new bit entering the MSB.
  - X takes 11 bits and Y takes 12 bits.
- LOAD: Y shifts on every edge until 12 bits are captured. X shifts only until 11 bits are captured, then holds. The edge that captures Y bit 11 moves to CONV.
- CONV (1 cycle):
  - fx and fy are combinational from the registers.
  - Magnitudes are formed zero-extended to 23 bits: |X| = fx ? -x_shift : x_shift, and likewise for Y.
  - -2048 (Y = 0x800 signed) must produce magnitude 2048 (unsigned 12-bit).
- MULT: 23 iterations of shift-add.
  - If multiplier LSB = 1, acc += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1.
  - All registers are 23 bits wide and overflow is discarded.
  - unsigned_done pulses on the cycle after iteration 23.
- FIX: z = (fx ^ fy) ? -acc : acc, mod 2^23. z is loaded into the output shift register.
- SOUT: 23 cycles; z_serial = sreg[0], then sreg shifts right. z holds its value.
- DONE: z_done=1. z and the shift registers hold. mul=1 re-enters LOAD; this is the same as the IDLE behaviour.
- sx and sy are sampled continuously; they must be held stable from CONV to FIX.

## Timing
- Reset: every register and output is 0 and the state is IDLE.
  - Reset mid-operation aborts immediately.
- Latency from the first capture edge:
  - 12 edges to load.
  - 1 edge for CONV.
  - 23 edges for MULT; the unsigned_done pulse is 36 edges after the first capture.
  - 1 edge for FIX.
  - 23 edges of z_serial.
  - z_done rises 60 edges after the first capture.
- mul is ignored outside IDLE and DONE.

## Configuration
- `SERIAL_MUL_SOUT_EN` defined: SOUT stage present, as described above.
- Undefined: no output shift register; z_serial is tied to 0. z_done asserts in the cycle after FIX (the product is valid).

## Structure
- Package `serial_mul_pkg`:
  - width constants XW=11, YW=12, ZW=23.
  - iteration count MUL_STEPS=23.
  - state enum.
- One natural sub-module, `unsigned_shift_add_mult`: start input, a[22:0], b[22:0], p[22:0], done. It runs the 23 iterations.

## Test plan
- sx=sy=1; x=1 for all 11 bits (X = -1); y=0 for 11 bits, then 1 (Y = -2048):
  - fx=fy=1, x_shift=0x7FF, y_shift=0x800.
  - z = 2048 (0x000800).
  - z_serial emits bit 11 high and all others low.
- sx=sy=0; same bits: unsigned 2047*2048 = 4192256 (0x3FF800) -> z=0x3FF800.
- sx=1, sy=0; X = -3 (0x7FD), Y = 5 -> z = -15 = 0x7FFFF1; fx=1, fy=0.
- X=0, any Y -> z=0; unsigned_done still pulses exactly 36 edges after the first capture.
- rst asserted during MULT: all outputs go to 0 immediately. A fresh mul=1 then gives a correct 5*7=35.
- Back-to-back: after z_done, mul=1 starts a new load; z_done clears on that edge.
